fetch_pc: RTL

//  Instruction-fetch PC unit for the MIMA RV32 pipeline. It holds the PC and issues fetch

---
 rtl/fetch_pc.sv | 115 +++++++++++
 1 files changed

// File: rtl/fetch_pc.sv
// rtl/fetch_pc.sv - RV32 instruction-fetch PC unit, one outstanding fetch, single-entry decode buffer
// Redirects from branch/jump retarget the PC and kill any wrong-path fetch still in flight.
module fetch_pc #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        jump_valid,
   input  logic [31:0] jump_target,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc,
   output logic        flush
);

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic [31:0] pc, pc_nxt;
   logic [31:0] req_pc, req_pc_nxt;
   logic [31:0] buf_data, buf_data_nxt;
   logic [31:0] buf_pc, buf_pc_nxt;
   logic        kill, kill_nxt;
   logic        redirect;
   logic [31:0] target;
   logic [31:0] pc_inc;

   // Jump wins if both fire; targets are always word aligned.
   assign redirect = br_taken | jump_valid;
   assign target   = (jump_valid ? jump_target : br_target) & 32'hFFFF_FFFC;
   assign pc_inc   = pc + 32'd4;

   assign flush          = redirect;
   assign imem_req_valid = (state == S_REQ);
   assign imem_req_addr  = pc;
   assign inst_valid     = (state == S_HOLD) & ~redirect;
   assign inst_data      = buf_data;
   assign inst_pc        = buf_pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_REQ;
         pc       <= RESET_PC;
         req_pc   <= 32'h0;
         buf_data <= 32'h0;
         buf_pc   <= 32'h0;
         kill     <= 1'b0;
      end else begin
         state    <= state_nxt;
         pc       <= pc_nxt;
         req_pc   <= req_pc_nxt;
         buf_data <= buf_data_nxt;
         buf_pc   <= buf_pc_nxt;
         kill     <= kill_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      pc_nxt       = pc;
      req_pc_nxt   = req_pc;
      buf_data_nxt = buf_data;
      buf_pc_nxt   = buf_pc;
      kill_nxt     = kill;
      case (state)
         S_REQ: begin
            if (imem_req_ready) begin
               req_pc_nxt = pc;
               pc_nxt     = pc_inc;
               kill_nxt   = redirect;
               state_nxt  = S_WAIT;
            end
         end
         S_WAIT: begin
            if (imem_rsp_valid) begin
               // A redirect coinciding with the response discards it directly.
               if (kill || redirect) begin
                  kill_nxt  = 1'b0;
                  state_nxt = S_REQ;
               end else begin
                  buf_data_nxt = imem_rsp_data;
                  buf_pc_nxt   = req_pc;
                  state_nxt    = S_HOLD;
               end
            end else if (redirect) begin
               kill_nxt = 1'b1;
            end
         end
         S_HOLD: begin
            if (redirect || inst_ready) begin
               state_nxt = S_REQ;
            end
         end
         default: begin
            state_nxt = S_REQ;
         end
      endcase
      if (redirect) begin
         pc_nxt = target;
      end
   end

endmodule
